// File: rtl/mii_rx_fcs.sv
// mii_rx_fcs: receive deframer and FCS checker for MII (W=4) or RMII (W=2) symbols.
// It strips the preamble and SFD, assembles octets LSB-first, and runs a reflected
// CRC-32 over every data symbol. At the end of each frame it reports good/bad
// status and the frame length, and it updates wrapping good/bad frame counters.
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   rxd, rx_dv    receive symbol (bit 0 is the earliest on the wire) and data valid
//   byte_out      assembled octet; byte_valid is a 1-cycle strobe for it
//   frame_end     1-cycle strobe; frame_good and frame_len are updated with it and held
//   good_count    count of good frames, wrapping at 2^16
//   bad_count     count of bad frames, wrapping at 2^16
module mii_rx_fcs #(
  parameter int W       = 4,
  parameter int MIN_PRE = 4,
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  rxd,
  input  logic          rx_dv,
  output logic [7:0]    byte_out,
  output logic          byte_valid,
  output logic          frame_end,
  output logic          frame_good,
  output logic [15:0]   frame_len,
  output logic [15:0]   good_count,
  output logic [15:0]   bad_count
);

  localparam int SPB = 8 / W;                      // symbols per byte
  localparam int SCW = (SPB > 2) ? $clog2(SPB) : 1;
  localparam logic [SCW-1:0] LAST_SYM = SCW'(SPB - 1);
  localparam logic [W-1:0]   PRE      = {(W/2){2'b01}};
  localparam logic [3:0]     SFD4     = (W == 4) ? 4'hD : 4'h3;
  localparam logic [W-1:0]   SFD      = SFD4[W-1:0];
  localparam logic [7:0]     MINP     = 8'(MIN_PRE);
  localparam logic [15:0]    MINL     = 16'(MIN_LEN);
  localparam logic [15:0]    MAXL     = 16'(MAX_LEN);
  localparam logic [31:0]    RESIDUE  = 32'hDEBB20E3;

  typedef enum logic [1:0] {DROP, IDLE, PREAMBLE, DATA} state_t;

  state_t         state;
  logic [7:0]     pre_cnt;
  logic [SCW-1:0] sym_cnt;
  logic [15:0]    len;
  logic [7:0]     sr;
  logic [31:0]    crc;
  logic           fcs_ok;

  // Reflected CRC-32, one bit per iteration, earliest bit first.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [W-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < W; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  // Evaluated on the edge that sees rx_dv fall. At that point every data symbol,
  // including the FCS, has already been folded into the CRC register.
  assign fcs_ok = (crc == RESIDUE) && (sym_cnt == '0) && (len >= MINL) && (len <= MAXL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= DROP;
      crc        <= 32'hFFFFFFFF;
      pre_cnt    <= '0;
      sym_cnt    <= '0;
      len        <= '0;
      sr         <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      frame_good <= 1'b0;
      frame_len  <= '0;
      good_count <= '0;
      bad_count  <= '0;
    end else begin
      byte_valid <= 1'b0;
      frame_end  <= 1'b0;
      case (state)
        // Never lock onto a frame that is already in progress.
        DROP: if (!rx_dv) state <= IDLE;
        IDLE: begin
          if (rx_dv) begin
            if (rxd == PRE) begin
              state   <= PREAMBLE;
              pre_cnt <= 8'd1;
            end else begin
              state <= DROP;
            end
          end
        end
        PREAMBLE: begin
          if (!rx_dv) begin
            state <= IDLE;
          end else if (rxd == PRE) begin
            if (pre_cnt != 8'hFF) pre_cnt <= pre_cnt + 8'd1;
          end else if (rxd == SFD && pre_cnt >= MINP) begin
            state   <= DATA;
            crc     <= 32'hFFFFFFFF;
            sym_cnt <= '0;
            len     <= '0;
          end else begin
            state <= DROP;
          end
        end
        DATA: begin
          if (rx_dv) begin
            sr  <= {rxd, sr[7:W]};
            crc <= crc_step(crc, rxd);
            if (sym_cnt == LAST_SYM) begin
              sym_cnt <= '0;
              if (len < MAXL) begin
                byte_out   <= {rxd, sr[7:W]};
                byte_valid <= 1'b1;
              end
              // The length saturates at MAX_LEN+1, which already marks the frame bad.
              if (len <= MAXL) len <= len + 16'd1;
            end else begin
              sym_cnt <= sym_cnt + SCW'(1);
            end
          end else begin
            state      <= IDLE;
            frame_end  <= 1'b1;
            frame_len  <= len;
            frame_good <= fcs_ok;
            if (fcs_ok) good_count <= good_count + 16'd1;
            else        bad_count  <= bad_count + 16'd1;
          end
        end
        default: state <= DROP;
      endcase
    end
  end

endmodule
